// File: rtl/vms_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vms_pkg
// Brief    : Shared types and opcode constants for the vector memory sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package vms_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } vms_state_t;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } vms_op_t;

    localparam logic [1:0] VLOAD    = 2'b10;
    localparam logic [1:0] VSTORE   = 2'b11;
    localparam logic [1:0] MEM_TYPE = 2'b00;

    // Decode helper for control_unit: true for "cargar vector" / "guardar vector".
    function automatic logic is_vec_mem(input logic [1:0] instruction_type,
                                        input logic [4:0] opcode);
        return (instruction_type == MEM_TYPE) &&
               ((opcode[4:3] == VLOAD) || (opcode[4:3] == VSTORE));
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_mem_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_mem_sequencer_if
// Brief    : Single-port scalar data memory bus (request/ack handshake).
// Revision : 1.0 - initial release
// ============================================================================
interface vector_mem_sequencer_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/vms_lane_buffer.sv
`default_nettype none
// ============================================================================
// Module   : vms_lane_buffer
// Brief    : LANES x DW register with bulk load, lane-indexed write and read.
// Revision : 1.0 - initial release
// ============================================================================
module vms_lane_buffer
    import vms_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int LW    = 2
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_load_all,
    input  wire logic [LANES*DW-1:0] i_load_data,
    input  wire logic                i_wr_en,
    input  wire logic [LW-1:0]       i_wr_lane,
    input  wire logic [DW-1:0]       i_wr_data,
    input  wire logic [LW-1:0]       i_rd_lane,
    output logic      [DW-1:0]       o_rd_data,
    output logic      [LANES*DW-1:0] o_q
);

    logic [DW-1:0] r_lane_q [LANES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) r_lane_q[i] <= '0;
        end else if (i_load_all) begin
            for (int i = 0; i < LANES; i++) r_lane_q[i] <= i_load_data[i*DW +: DW];
        end else if (i_wr_en) begin
            r_lane_q[i_wr_lane] <= i_wr_data;
        end
    end

    assign o_rd_data = r_lane_q[i_rd_lane];

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign o_q[g*DW +: DW] = r_lane_q[g];
    end

endmodule
`default_nettype wire

// File: rtl/vector_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_mem_sequencer
// Brief    : Splits a vector load/store into LANES scalar memory accesses and
//            stalls the pipeline meanwhile. Optional ack watchdog: VMS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vector_mem_sequencer
    import vms_pkg::*;
#(
    parameter int LANES          = 4,
    parameter int DW             = 8,
    parameter int AW             = 16,
    parameter int STRIDE         = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                start_load,
    input  wire logic                start_store,
    input  wire logic [AW-1:0]       base_addr,
    input  wire logic [LANES*DW-1:0] vec_wdata,
    vector_mem_sequencer_if.master   mem,
    output logic      [LANES*DW-1:0] vreg_wdata,
    output logic                     vreg_we,
    output logic                     stall,
    output logic                     done,
    output logic                     err
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] C_LAST_LANE = LW'(LANES - 1);

    if (LANES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("vector_mem_sequencer: LANES and TIMEOUT_CYCLES must be >= 1");
    end

    vms_state_t          r_state;
    vms_state_t          w_state_next;
    vms_op_t             r_op;
    logic [AW-1:0]       r_base;
    logic [LW-1:0]       r_lane;
    logic [LANES*DW-1:0] r_vreg_hold;
    logic [LANES*DW-1:0] w_buf_q;
    logic [DW-1:0]       w_lane_wdata;
    logic [AW-1:0]       w_addr;
    logic                w_start;
    logic                w_accept;
    logic                w_lane_ack;

    assign w_start    = start_load | start_store;
    assign w_accept   = (r_state == IDLE) && w_start;
    assign w_lane_ack = (r_state == ACCESS) && mem.ack;
    assign w_addr     = r_base + AW'(int'(r_lane) * STRIDE);

    // Bulk-loaded at start (store data); lanes overwritten as load reads return.
    vms_lane_buffer #(
        .LANES (LANES),
        .DW    (DW),
        .LW    (LW)
    ) u_lane_buffer (
        .clk         (clk),
        .rst         (rst),
        .i_load_all  (w_accept),
        .i_load_data (vec_wdata),
        .i_wr_en     (w_lane_ack && (r_op == OP_LOAD)),
        .i_wr_lane   (r_lane),
        .i_wr_data   (mem.rdata),
        .i_rd_lane   (r_lane),
        .o_rd_data   (w_lane_wdata),
        .o_q         (w_buf_q)
    );

`ifdef VMS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait;
    logic          r_err;
    logic          w_timeout;

    assign w_timeout = (r_wait == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wait <= ((r_state == ACCESS) && !mem.ack) ? r_wait + 1'b1 : '0;
            if (w_state_next == ERR) r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (w_start) w_state_next = ACCESS;
            ACCESS: begin
                if (mem.ack) begin
                    if (r_lane == C_LAST_LANE) w_state_next = DONE;
`ifdef VMS_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_state_next = ERR;
`endif
                end
            end
            DONE:    w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= OP_LOAD;
            r_base      <= '0;
            r_lane      <= '0;
            r_vreg_hold <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                // Load has priority when both requests arrive together.
                r_op   <= start_load ? OP_LOAD : OP_STORE;
                r_base <= base_addr;
                r_lane <= '0;
            end else if (w_lane_ack && (r_lane != C_LAST_LANE)) begin
                r_lane <= r_lane + 1'b1;
            end
            if ((r_state == DONE) && (r_op == OP_LOAD)) r_vreg_hold <= w_buf_q;
        end
    end

    assign mem.req    = (r_state == ACCESS);
    assign mem.we     = (r_state == ACCESS) && (r_op == OP_STORE);
    assign mem.addr   = (r_state == ACCESS) ? w_addr : '0;
    assign mem.wdata  = (r_state == ACCESS) ? w_lane_wdata : '0;

    assign done       = (r_state == DONE) || (r_state == ERR);
    assign vreg_we    = (r_state == DONE) && (r_op == OP_LOAD);
    assign vreg_wdata = vreg_we ? w_buf_q : r_vreg_hold;
    assign stall      = w_start || (r_state == ACCESS);

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_mem_sequencer
// Brief    : Randomized self-checking bench with a memory model and an
//            address/data reference model for vector_mem_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_mem_sequencer;

    localparam int LANES  = 4;
    localparam int DW     = 8;
    localparam int AW     = 16;
    localparam int STRIDE = 1;
    localparam int TO_CYC = 8;

    logic                clk;
    logic                rst;
    logic                start_load;
    logic                start_store;
    logic [AW-1:0]       base_addr;
    logic [LANES*DW-1:0] vec_wdata;
    logic [LANES*DW-1:0] vreg_wdata;
    logic                vreg_we;
    logic                stall;
    logic                done;
    logic                err;

    vector_mem_sequencer_if #(.AW(AW), .DW(DW)) mem_if ();

    vector_mem_sequencer #(
        .LANES          (LANES),
        .DW             (DW),
        .AW             (AW),
        .STRIDE         (STRIDE),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_load  (start_load),
        .start_store (start_store),
        .base_addr   (base_addr),
        .vec_wdata   (vec_wdata),
        .mem         (mem_if.master),
        .vreg_wdata  (vreg_wdata),
        .vreg_we     (vreg_we),
        .stall       (stall),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  sim_mem [65536];
    logic [7:0]  ref_mem [65536];
    logic [31:0] last_vreg;
    logic        exp_err;
    int          n_checks;
    int          n_pass;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_req"},   32'(mem_if.req),   0);
        check_val({tag, "_we"},    32'(mem_if.we),    0);
        check_val({tag, "_addr"},  32'(mem_if.addr),  0);
        check_val({tag, "_wdata"}, 32'(mem_if.wdata), 0);
        check_val({tag, "_vreg"},  vreg_wdata,        0);
        check_val({tag, "_vwe"},   32'(vreg_we),      0);
        check_val({tag, "_done"},  32'(done),         0);
        check_val({tag, "_err"},   32'(err),          0);
        check_val({tag, "_stall"}, 32'(stall),        0);
    endtask

    task automatic do_reset();
        start_load = 1'b0; start_store = 1'b0;
        mem_if.ack = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        last_vreg = '0;
        exp_err   = 1'b0;
        check_idle_zero("rst");
    endtask

    // One vector operation with per-lane ack delays drawn from [dmin,dmax].
    // abort_lane >= 0 asserts rst right after that lane's ack.
    task automatic run_op(input bit is_load, input bit both, input logic [15:0] base,
                          input logic [31:0] wdat, input int dmin, input int dmax,
                          input int abort_lane);
        int          d [LANES];
        logic [15:0] ea [LANES];
        logic [31:0] exp_vreg;
        for (int i = 0; i < LANES; i++) begin
            d[i]  = $urandom_range(dmax, dmin);
            ea[i] = base + 16'(i * STRIDE);
            exp_vreg[i*8 +: 8] = ref_mem[ea[i]];
        end
        start_load  = is_load | both;
        start_store = ~is_load | both;
        base_addr   = base;
        vec_wdata   = wdat;
        #1;
        check_val("start_stall", 32'(stall), 1);
        check_val("start_req", 32'(mem_if.req), 0);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < LANES; i++) begin
            for (int w = 0; w <= d[i]; w++) begin
                start_load = 1'b0; start_store = 1'b0;
                #1;
                check_val("acc_req",   32'(mem_if.req),  1);
                check_val("acc_we",    32'(mem_if.we),   32'(!is_load));
                check_val("acc_addr",  32'(mem_if.addr), 32'(ea[i]));
                if (!is_load) check_val("acc_wdata", 32'(mem_if.wdata), 32'(wdat[i*8 +: 8]));
                check_val("acc_stall", 32'(stall),   1);
                check_val("acc_done",  32'(done),    0);
                check_val("acc_vwe",   32'(vreg_we), 0);
                if (w == d[i]) begin
                    mem_if.ack   = 1'b1;
                    mem_if.rdata = sim_mem[mem_if.addr];
                    if (!is_load) sim_mem[mem_if.addr] = mem_if.wdata;
                end else begin
                    mem_if.ack   = 1'b0;
                    mem_if.rdata = 8'($urandom);
                end
                if ($urandom_range(3, 0) == 0) begin
                    start_load  = 1'($urandom);
                    start_store = 1'($urandom);
                    base_addr   = 16'($urandom);
                    vec_wdata   = $urandom;
                end
                @(posedge clk); @(negedge clk);
            end
            if (i == abort_lane) begin
                start_load = 1'b0; start_store = 1'b0;
                mem_if.ack = 1'b0;
                rst = 1'b1;
                @(posedge clk); @(negedge clk);
                rst = 1'b0;
                #1;
                last_vreg = '0;
                exp_err   = 1'b0;
                check_idle_zero("abort");
                return;
            end
        end
        if (!is_load)
            for (int i = 0; i < LANES; i++) ref_mem[ea[i]] = wdat[i*8 +: 8];
        start_load = 1'b0; start_store = 1'b0;
        mem_if.ack = 1'b0;
        #1;
        check_val("done_done",  32'(done),       1);
        check_val("done_vwe",   32'(vreg_we),    32'(is_load));
        check_val("done_stall", 32'(stall),      0);
        check_val("done_req",   32'(mem_if.req), 0);
        check_val("done_err",   32'(err),        32'(exp_err));
        if (is_load) begin
            check_val("done_vreg", vreg_wdata, exp_vreg);
            last_vreg = exp_vreg;
        end
        @(posedge clk); @(negedge clk);
        #1;
        check_val("idle_done",  32'(done),       0);
        check_val("idle_vwe",   32'(vreg_we),    0);
        check_val("idle_req",   32'(mem_if.req), 0);
        check_val("idle_stall", 32'(stall),      0);
        check_val("idle_vreg",  vreg_wdata,      last_vreg);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        n_checks = 0; n_pass = 0;
        rst = 1'b1; start_load = 1'b0; start_store = 1'b0;
        base_addr = '0; vec_wdata = '0;
        mem_if.ack = 1'b0; mem_if.rdata = '0;
        for (int a = 0; a < 65536; a++) begin
            b = 8'($urandom);
            sim_mem[a] = b;
            ref_mem[a] = b;
        end
        for (int a = 0; a < 4; a++) begin
            b = 8'(8'h11 * (a + 1));
            sim_mem[16'h10 + a] = b;
            ref_mem[16'h10 + a] = b;
        end
        @(negedge clk);
        do_reset();

        // Directed: load, store with 2-cycle waits, wrap, simultaneous starts.
        run_op(1'b1, 1'b0, 16'h0010, 32'h0, 0, 0, -1);
        check_val("load_known", vreg_wdata, 32'h44332211);
        run_op(1'b0, 1'b0, 16'h0020, 32'hA1B2C3D4, 2, 2, -1);
        check_val("store_mem", {sim_mem[16'h23], sim_mem[16'h22], sim_mem[16'h21], sim_mem[16'h20]},
                  32'hA1B2C3D4);
        check_val("store_vreg_kept", vreg_wdata, 32'h44332211);
        run_op(1'b1, 1'b0, 16'hFFFE, 32'h0, 0, 1, -1);
        run_op(1'b1, 1'b1, 16'h0020, 32'h5A5A5A5A, 0, 1, -1);
        check_val("both_load", vreg_wdata, 32'hA1B2C3D4);

        // Reset mid-operation, then a fresh load.
        run_op(1'b1, 1'b0, 16'h0100, 32'h0, 0, 1, 1);
        run_op(1'b1, 1'b0, 16'h0010, 32'h0, 0, 0, -1);

        // Random mix.
        for (int k = 0; k < 24; k++) begin
            bit ld, bo;
            ld = 1'($urandom);
            bo = ld & ($urandom_range(3, 0) == 0);
            run_op(ld, bo, 16'($urandom), $urandom, 0, 3, -1);
        end

`ifdef VMS_TIMEOUT_EN
        start_load = 1'b1; base_addr = 16'h0040;
        @(posedge clk); @(negedge clk);
        start_load = 1'b0;
        for (int c = 0; c < TO_CYC; c++) begin
            #1;
            check_val("to_req", 32'(mem_if.req), 1);
            check_val("to_err_low", 32'(err), 0);
            @(posedge clk); @(negedge clk);
        end
        #1;
        check_val("to_err",  32'(err),        1);
        check_val("to_done", 32'(done),       1);
        check_val("to_vwe",  32'(vreg_we),    0);
        check_val("to_req0", 32'(mem_if.req), 0);
        @(posedge clk); @(negedge clk);
        #1;
        check_val("to_done_once", 32'(done), 0);
        check_val("to_sticky",    32'(err),  1);
        exp_err = 1'b1;
        run_op(1'b1, 1'b0, 16'h0010, 32'h0, 0, 0, -1);
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
